// File: rtl/race_sample_tx_if.sv
// Producer stream (s_*) and filter-side slot bus (strobe/tx_*) of the RACE sample transmitter.
// Slave = transmitter, master = the environment that drives samples and observes the slot bus.
interface race_sample_tx_if #(
  parameter int SAMPLE_SIZE = 16
) ();
  logic                   s_valid;
  logic                   s_ready;
  logic [SAMPLE_SIZE-1:0] s_real;
  logic [SAMPLE_SIZE-1:0] s_imag;
  logic                   s_flag;
  logic                   strobe;
  logic                   tx_valid;
  logic [SAMPLE_SIZE-1:0] tx_real;
  logic [SAMPLE_SIZE-1:0] tx_imag;

  modport slave (
    input  s_valid, s_real, s_imag, s_flag,
    output s_ready, strobe, tx_valid, tx_real, tx_imag
  );

  modport master (
    output s_valid, s_real, s_imag, s_flag,
    input  s_ready, strobe, tx_valid, tx_real, tx_imag
  );
endinterface

// File: rtl/race_sample_tx.sv
// Strobe-paced sample transmitter: FIFO-buffered samples leave one per PERIOD-clock slot, data at slot start,
// strobe 2 clocks later; s_ready = !full, pop only at slot start (no fall-through), underrun pulse on empty slot.
module race_sample_tx #(
  parameter int SAMPLE_SIZE = 16,
  parameter int FIFO_AW     = 3,
  parameter int PERIOD      = 32,
  parameter int STROBE_HIGH = 8
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic                 enable_i,
  race_sample_tx_if.slave      bus,
  output logic                 underrun_o,
  output logic [FIFO_AW:0]     fifo_level_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = 2 * SAMPLE_SIZE + 1;
  localparam int CW    = 8;
  localparam logic [CW-1:0]    CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0]    STB_FIRST = CW'(2);
  localparam logic [CW-1:0]    STB_LAST  = CW'(STROBE_HIGH + 1);
  localparam logic [FIFO_AW:0] LVL_FULL  = (FIFO_AW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   slot_start;
  logic [EW-1:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]       level_q;
  logic                   full, empty, push, pop;
  logic [EW-1:0]          head;
  logic                   strobe_q, strobe_d;
  logic                   tx_valid_q;
  logic [SAMPLE_SIZE-1:0] tx_real_q, tx_imag_q;
  logic                   underrun_q;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign push  = bus.s_valid & ~full;
  assign pop   = slot_start & ~empty;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_start = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_i) begin
          state_d    = RUN;
          slot_start = 1'b1;
        end
      end
      RUN: begin
        // A dropped enable only takes effect at the wrap, so the slot and its strobe always finish.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (enable_i) slot_start = 1'b1;
          else          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    strobe_d = (state_d == RUN) && (cnt_d >= STB_FIRST) && (cnt_d <= STB_LAST);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_real_q  <= '0;
      tx_imag_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      strobe_q   <= strobe_d;
      underrun_q <= slot_start & empty;
      if (pop) begin
        tx_valid_q <= head[EW-1];
        tx_real_q  <= head[EW-2 -: SAMPLE_SIZE];
        tx_imag_q  <= head[SAMPLE_SIZE-1:0];
      end else if (slot_start) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (FIFO_AW+1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {bus.s_flag, bus.s_real, bus.s_imag};
  end

  assign bus.s_ready   = ~full;
  assign bus.strobe    = strobe_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_real   = tx_real_q;
  assign bus.tx_imag   = tx_imag_q;
  assign underrun_o    = underrun_q;
  assign fifo_level_o  = level_q;
endmodule

// File: tb/tb_race_sample_tx.sv
// Bench for race_sample_tx: directed scenarios then random traffic, every cycle compared to a slot-level queue model.
module tb_race_sample_tx;
  localparam int SS    = 16;
  localparam int AW    = 3;
  localparam int P     = 32;
  localparam int SH    = 8;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic          f;
    logic [SS-1:0] re;
    logic [SS-1:0] im;
  } smp_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic          enable;
  logic          underrun;
  logic [AW:0]   fifo_level;

  always #5 clk = ~clk;

  race_sample_tx_if #(.SAMPLE_SIZE(SS)) bus ();

  race_sample_tx #(
    .SAMPLE_SIZE(SS), .FIFO_AW(AW), .PERIOD(P), .STROBE_HIGH(SH)
  ) dut (
    .clk_i(clk), .nrst_i(nrst), .enable_i(enable), .bus(bus),
    .underrun_o(underrun), .fifo_level_o(fifo_level)
  );

  int tests = 0;
  int fails = 0;

  // Reference: the FIFO is a queue, the slot generator is "running" plus position within the slot.
  smp_t          mq[$];
  bit            m_run;
  int            m_pos;
  logic          m_valid;
  logic [SS-1:0] m_re, m_im;
  logic          m_unr;
  bit            acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_pos = 0; m_valid = 1'b0; m_re = '0; m_im = '0; m_unr = 1'b0;
  endtask

  task automatic check_all();
    chk("strobe",     32'(bus.strobe),   32'(m_run && m_pos >= 2 && m_pos < 2 + SH));
    chk("tx_valid",   32'(bus.tx_valid), 32'(m_valid));
    chk("tx_real",    32'(bus.tx_real),  32'(m_re));
    chk("tx_imag",    32'(bus.tx_imag),  32'(m_im));
    chk("underrun",   32'(underrun),     32'(m_unr));
    chk("fifo_level", 32'(fifo_level),   32'(mq.size()));
    chk("s_ready",    32'(bus.s_ready),  32'(mq.size() < DEPTH));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare 1 time unit later.
  task automatic step();
    bit   slot;
    smp_t s;
    acc = bus.s_valid && (mq.size() < DEPTH);
    @(posedge clk);
    slot = enable && (!m_run || m_pos == P - 1);
    if (m_run) begin
      if (m_pos == P - 1) begin
        m_pos = 0;
        m_run = enable;
      end else m_pos++;
    end else if (enable) begin
      m_run = 1; m_pos = 0;
    end
    m_unr = slot && (mq.size() == 0);
    if (slot) begin
      if (mq.size() > 0) begin
        s = mq.pop_front();
        m_valid = s.f; m_re = s.re; m_im = s.im;
      end else m_valid = 1'b0;
    end
    if (acc) begin
      s.f = bus.s_flag; s.re = bus.s_real; s.im = bus.s_imag;
      mq.push_back(s);
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic f, input logic [SS-1:0] re, input logic [SS-1:0] im);
    bus.s_valid = v; bus.s_flag = f; bus.s_real = re; bus.s_imag = im;
  endtask

  task automatic rst_pulse();
    enable = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    nrst = 1'b0;
    model_reset();
    @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic idle_out();
    enable = 1'b0;
    bus.s_valid = 1'b0;
    repeat (P + 4) step();
  endtask

  initial begin
    int n;
    int k;
    nrst   = 1'b0;
    enable = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    model_reset();
    #12;
    chk("rst_strobe",   32'(bus.strobe),   32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_real",  32'(bus.tx_real),  32'd0);
    chk("rst_underrun", 32'(underrun),     32'd0);
    chk("rst_level",    32'(fifo_level),   32'd0);
    chk("rst_s_ready",  32'(bus.s_ready),  32'd1);
    @(posedge clk);
    #1 nrst = 1'b1;

    // Basic stream: three samples, one per slot.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, logic'(i < 3), SS'(i), SS'(16'h8000 | i));
      step();
    end
    bus.s_valid = 1'b0;
    enable = 1'b1;
    step();
    chk("basic_s1_real", 32'(bus.tx_real),  32'h0001);
    chk("basic_s1_imag", 32'(bus.tx_imag),  32'h8001);
    chk("basic_s1_vld",  32'(bus.tx_valid), 32'd1);
    n = 0; k = -1;
    for (int i = 1; i < P; i++) begin
      step();
      if (bus.strobe) n++;
      if (bus.strobe && k < 0) k = i;
    end
    chk("basic_strobe_width", 32'(n), 32'(SH));
    chk("basic_strobe_rise",  32'(k), 32'd2);
    chk("basic_s1_hold",      32'(bus.tx_real), 32'h0001);
    step();
    chk("basic_s2_real", 32'(bus.tx_real),  32'h0002);
    chk("basic_s2_vld",  32'(bus.tx_valid), 32'd1);
    repeat (P) step();
    chk("basic_s3_real", 32'(bus.tx_real),  32'h0003);
    chk("basic_s3_vld",  32'(bus.tx_valid), 32'd0);
    idle_out();

    // Underrun: one sample, then a slot with an empty FIFO.
    rst_pulse();
    drive(1'b1, 1'b1, 16'h1234, 16'h5678);
    step();
    bus.s_valid = 1'b0;
    enable = 1'b1;
    repeat (P + 1) step();
    chk("unr_pulse", 32'(underrun),     32'd1);
    chk("unr_real",  32'(bus.tx_real),  32'h1234);
    chk("unr_imag",  32'(bus.tx_imag),  32'h5678);
    chk("unr_vld",   32'(bus.tx_valid), 32'd0);
    step();
    chk("unr_one_cycle", 32'(underrun), 32'd0);
    step();
    chk("unr_strobe", 32'(bus.strobe), 32'd1);
    idle_out();

    // Full / backpressure: s_valid held, 9 samples offered.
    rst_pulse();
    k = 0;
    repeat (10) begin
      drive(1'b1, 1'b1, SS'(16'h0100 + k), SS'(16'h0200 + k));
      step();
      if (acc) k++;
    end
    chk("full_accepted", 32'(k),           32'd8);
    chk("full_level",    32'(fifo_level),  32'd8);
    chk("full_s_ready",  32'(bus.s_ready), 32'd0);
    enable = 1'b1;
    step();
    chk("full_pop_ready", 32'(bus.s_ready), 32'd1);
    chk("full_pop_level", 32'(fifo_level),  32'd7);
    chk("full_pop_head",  32'(bus.tx_real), 32'h0100);
    step();
    chk("full_9th_acc",   32'(acc),         32'd1);
    chk("full_9th_level", 32'(fifo_level),  32'd8);
    idle_out();

    // Enable dropped at cnt=5: slot completes, exactly one strobe and one pop.
    rst_pulse();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, SS'(16'h0A00 + i), SS'(16'h0B00 + i));
      step();
    end
    bus.s_valid = 1'b0;
    enable = 1'b1;
    step();
    n = 0;
    repeat (5) begin
      step();
      if (bus.strobe) n++;
    end
    enable = 1'b0;
    repeat (2 * P + 6) begin
      step();
      if (bus.strobe) n++;
    end
    chk("drop_strobes", 32'(n),          32'(SH));
    chk("drop_level",   32'(fifo_level), 32'd1);

    // Async reset at cnt=4 while the strobe is high.
    enable = 1'b1;
    step();
    repeat (4) step();
    chk("ar_strobe_pre", 32'(bus.strobe), 32'd1);
    enable = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("ar_strobe",  32'(bus.strobe),   32'd0);
    chk("ar_valid",   32'(bus.tx_valid), 32'd0);
    chk("ar_real",    32'(bus.tx_real),  32'd0);
    chk("ar_imag",    32'(bus.tx_imag),  32'd0);
    chk("ar_level",   32'(fifo_level),   32'd0);
    chk("ar_s_ready", 32'(bus.s_ready),  32'd1);
    model_reset();
    @(posedge clk);
    #1 nrst = 1'b1;
    repeat (4) step();

    // Push and pop in the same slot-start cycle with level 1.
    drive(1'b1, 1'b1, 16'hAAAA, 16'h5555);
    step();
    drive(1'b1, 1'b1, 16'hBBBB, 16'h4444);
    enable = 1'b1;
    step();
    bus.s_valid = 1'b0;
    chk("pp_level", 32'(fifo_level),  32'd1);
    chk("pp_old",   32'(bus.tx_real), 32'hAAAA);
    repeat (P) step();
    chk("pp_new",       32'(bus.tx_real), 32'hBBBB);
    chk("pp_new_level", 32'(fifo_level),  32'd0);
    idle_out();

    // Random traffic against the model.
    rst_pulse();
    for (int blk = 0; blk < 6; blk++) begin
      int rate;
      rate = $urandom_range(1, 12);
      repeat (500) begin
        if ($urandom_range(0, 199) == 0) enable = ~enable;
        else if (blk > 0 && $urandom_range(0, 99) == 0) enable = 1'b1;
        if (!bus.s_valid || acc)
          drive(logic'($urandom_range(0, 99) < rate), logic'($urandom_range(0, 1)),
                SS'($urandom), SS'($urandom));
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
